// File: rtl/mem_responder.sv
// mem_responder: one single-port word array serving the IC fetch port and the DM data port,
// with round-robin arbitration, a fixed grant-to-ready latency and one-cycle ready pulses.
module mem_responder #(
  parameter int    XLEN      = 32,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_IC_DataReq,
  input  logic [XLEN-1:0] i_IM_Addr,
  output logic            o_IC_MemReady,
  output logic [XLEN-1:0] o_IM_Instr,
  input  logic            i_DM_Wen,
  input  logic            i_DM_MemRead,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [2:0]      i_DM_f3,
  output logic            o_DM_data_ready,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_busy
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and capture the winning request
  // WAIT  | latency padding, count runs 1..LATENCY-1
  // RESP  | ready pulse to the granted port; a write commits at the closing edge

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   count_q, count_n;
  logic            last_dm_q;
  logic            gnt_dm_q;
  logic            wr_q;
  logic [2:0]      f3_q;
  logic [1:0]      lo_q;
  logic [AW-1:0]   idx_q;
  logic            inr_q;
  logic [XLEN-1:0] wd_q;

  logic [XLEN-1:0] mem [DEPTH];

  logic            ic_req, dm_req;
  logic            grant, pick_dm;
  logic [XLEN-1:0] in_addr;
  logic            in_wr, in_inr;
  logic            sel_dm, sel_wr, sel_inr;
  logic [AW-1:0]   sel_idx;
  logic            load_rd;
  logic [XLEN-1:0] rd_word;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wdat;

  assign ic_req = i_IC_DataReq;
  assign dm_req = i_DM_Wen | i_DM_MemRead;

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    grant   = 1'b0;
    pick_dm = 1'b0;
    case (state_q)
      IDLE: begin
        if (ic_req || dm_req) begin
          grant   = 1'b1;
          pick_dm = dm_req && (!ic_req || !last_dm_q);
          count_n = CW'(1);
          state_n = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (count_q == CW'(LATENCY - 1)) state_n = RESP;
        else                             count_n = count_q + CW'(1);
      end
      RESP: begin
        state_n = IDLE;
        count_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_addr = pick_dm ? i_DM_Addr : i_IM_Addr;
  assign in_wr   = pick_dm && i_DM_Wen;
  assign in_inr  = (in_addr[XLEN-1:AW+2] == '0);

  // With LATENCY==1 the read happens on the grant edge, so use the live request fields then.
  assign sel_dm  = (state_q == IDLE) ? pick_dm : gnt_dm_q;
  assign sel_wr  = (state_q == IDLE) ? in_wr : wr_q;
  assign sel_inr = (state_q == IDLE) ? in_inr : inr_q;
  assign sel_idx = (state_q == IDLE) ? in_addr[AW+1:2] : idx_q;
  assign load_rd = (state_n == RESP) && !sel_wr;
  assign rd_word = sel_inr ? mem[sel_idx] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      last_dm_q     <= 1'b0;
      gnt_dm_q      <= 1'b0;
      wr_q          <= 1'b0;
      f3_q          <= '0;
      lo_q          <= '0;
      idx_q         <= '0;
      inr_q         <= 1'b0;
      wd_q          <= '0;
      o_IM_Instr    <= '0;
      o_DM_ReadData <= '0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      if (grant) begin
        last_dm_q <= pick_dm;
        gnt_dm_q  <= pick_dm;
        wr_q      <= in_wr;
        f3_q      <= i_DM_f3;
        lo_q      <= in_addr[1:0];
        idx_q     <= in_addr[AW+1:2];
        inr_q     <= in_inr;
        wd_q      <= i_DM_Wd;
      end
      if (load_rd) begin
        if (sel_dm) o_DM_ReadData <= rd_word;
        else        o_IM_Instr    <= rd_word;
      end
    end
  end

  always_comb begin
    be   = '1;
    wdat = wd_q;
    case (f3_q)
      3'b000: begin
        be   = NB'(1) << lo_q;
        wdat = {NB{wd_q[7:0]}};
      end
      3'b001: begin
        be   = NB'(3) << {lo_q[1], 1'b0};
        wdat = {(NB/2){wd_q[15:0]}};
      end
      default: ;
    endcase
  end

  // State is forced to IDLE asynchronously, so a reset drops any pending write.
  always_ff @(posedge i_clk) begin
    if (state_q == RESP && wr_q && inr_q) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign o_busy          = (state_q != IDLE);
  assign o_IC_MemReady   = (state_q == RESP) && !gnt_dm_q;
  assign o_DM_data_ready = (state_q == RESP) && gnt_dm_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 instance for most scenarios and a LATENCY=1 instance
// for back-to-back reads; expected ready pulses are queued at issue and popped on each pulse.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        ic_req = 0;
  logic [31:0] ic_addr = '0;
  logic        ic_ready;
  logic [31:0] ic_instr;
  logic        dm_wen = 0, dm_rd = 0;
  logic [31:0] dm_addr = '0, dm_wd = '0;
  logic [2:0]  dm_f3 = 3'b010;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        busy;

  logic        ic1_req = 0;
  logic [31:0] ic1_addr = '0;
  logic        ic1_ready;
  logic [31:0] ic1_instr;
  logic        dm1_wen = 0, dm1_rd = 0;
  logic [31:0] dm1_addr = '0, dm1_wd = '0;
  logic [2:0]  dm1_f3 = 3'b010;
  logic        dm1_ready;
  logic [31:0] dm1_rdata;
  logic        busy1;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q_ic[$];
  exp_t q_dm[$];
  exp_t q_dm1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.XLEN(32), .DEPTH(1024), .LATENCY(2), .INIT_FILE("")) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_IC_DataReq(ic_req), .i_IM_Addr(ic_addr), .o_IC_MemReady(ic_ready), .o_IM_Instr(ic_instr),
    .i_DM_Wen(dm_wen), .i_DM_MemRead(dm_rd), .i_DM_Addr(dm_addr), .i_DM_Wd(dm_wd),
    .i_DM_f3(dm_f3), .o_DM_data_ready(dm_ready), .o_DM_ReadData(dm_rdata), .o_busy(busy)
  );

  mem_responder #(.XLEN(32), .DEPTH(1024), .LATENCY(1), .INIT_FILE("")) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_IC_DataReq(ic1_req), .i_IM_Addr(ic1_addr), .o_IC_MemReady(ic1_ready), .o_IM_Instr(ic1_instr),
    .i_DM_Wen(dm1_wen), .i_DM_MemRead(dm1_rd), .i_DM_Addr(dm1_addr), .i_DM_Wd(dm1_wd),
    .i_DM_f3(dm1_f3), .o_DM_data_ready(dm1_ready), .o_DM_ReadData(dm1_rdata), .o_busy(busy1)
  );

  // Scoreboard: each ready pulse pops the oldest expectation for that port.
  always @(negedge clk) begin
    exp_t e;
    if (ic_ready) begin
      checks++;
      if (q_ic.size() == 0) begin
        failures++;
        $display("FAIL ic_unexpected_ready cyc=%0d instr=%h", cyc, ic_instr);
      end else begin
        e = q_ic.pop_front();
        if (cyc !== e.due) begin
          failures++;
          $display("FAIL ic_ready_cycle got=%0d want=%0d", cyc, e.due);
        end
        checks++;
        if (ic_instr !== e.data) begin
          failures++;
          $display("FAIL ic_instr got=%h want=%h", ic_instr, e.data);
        end
      end
    end
    if (dm_ready) begin
      checks++;
      if (q_dm.size() == 0) begin
        failures++;
        $display("FAIL dm_unexpected_ready cyc=%0d", cyc);
      end else begin
        e = q_dm.pop_front();
        if (cyc !== e.due) begin
          failures++;
          $display("FAIL dm_ready_cycle got=%0d want=%0d", cyc, e.due);
        end
        if (e.rd) begin
          checks++;
          if (dm_rdata !== e.data) begin
            failures++;
            $display("FAIL dm_rdata got=%h want=%h", dm_rdata, e.data);
          end
        end
      end
    end
    if (dm1_ready) begin
      checks++;
      if (q_dm1.size() == 0) begin
        failures++;
        $display("FAIL dm1_unexpected_ready cyc=%0d", cyc);
      end else begin
        e = q_dm1.pop_front();
        if (cyc !== e.due) begin
          failures++;
          $display("FAIL dm1_ready_cycle got=%0d want=%0d", cyc, e.due);
        end
        if (e.rd) begin
          checks++;
          if (dm1_rdata !== e.data) begin
            failures++;
            $display("FAIL dm1_rdata got=%h want=%h", dm1_rdata, e.data);
          end
        end
      end
    end
  end

  // Issue one DM access on instance `which`, hold it until the cycle after its ready, then drop.
  task automatic dm_op(input int which, input bit wen, input bit ren, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    int   lat;
    lat    = (which == 0) ? 2 : 1;
    e.rd   = !wen;
    e.data = exp_rd;
    e.due  = cyc + lat;
    if (which == 0) begin
      dm_wen = wen; dm_rd = ren; dm_addr = addr; dm_f3 = f3; dm_wd = wd;
      q_dm.push_back(e);
    end else begin
      dm1_wen = wen; dm1_rd = ren; dm1_addr = addr; dm1_f3 = f3; dm1_wd = wd;
      q_dm1.push_back(e);
    end
    repeat (lat + 1) begin @(posedge clk); #1; end
    dm_wen = 0; dm_rd = 0; dm1_wen = 0; dm1_rd = 0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (ic_ready !== 1'b0) begin failures++; $display("FAIL rst_ic_ready got=%b want=0", ic_ready); end
    checks++; if (dm_ready !== 1'b0) begin failures++; $display("FAIL rst_dm_ready got=%b want=0", dm_ready); end
    checks++; if (ic_instr !== 32'h0) begin failures++; $display("FAIL rst_ic_instr got=%h want=0", ic_instr); end
    checks++; if (dm_rdata !== 32'h0) begin failures++; $display("FAIL rst_dm_rdata got=%h want=0", dm_rdata); end
  endtask

  task automatic test_fetch();
    exp_t e;
    int   t;
    dm_op(0, 1, 0, 32'h10, 3'b010, 32'h00500093, 32'h0);
    t = cyc;
    ic_req = 1; ic_addr = 32'h10;
    e.rd = 1; e.data = 32'h00500093; e.due = t + 2;
    q_ic.push_back(e);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fetch_busy_t got=%b want=0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fetch_busy_t1 got=%b want=1", busy); end
    checks++; if (ic_ready !== 1'b0) begin failures++; $display("FAIL fetch_ready_t1 got=%b want=0", ic_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fetch_busy_t2 got=%b want=1", busy); end
    @(posedge clk); #1;
    ic_req = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fetch_busy_t3 got=%b want=0", busy); end
    checks++; if (ic_instr !== 32'h00500093) begin failures++; $display("FAIL fetch_hold got=%h want=00500093", ic_instr); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_half();
    dm_op(0, 1, 1, 32'h20, 3'b010, 32'hAABBCCDD, 32'h0);
    dm_op(0, 1, 0, 32'h22, 3'b000, 32'h00000011, 32'h0);
    dm_op(0, 1, 0, 32'h20, 3'b001, 32'h00007788, 32'h0);
    dm_op(0, 0, 1, 32'h20, 3'b010, 32'h0, 32'hAA117788);
    dm_op(0, 1, 0, 32'h24, 3'b010, 32'h00000000, 32'h0);
    dm_op(0, 1, 0, 32'h27, 3'b000, 32'hFFFFFF55, 32'h0);
    dm_op(0, 1, 0, 32'h26, 3'b001, 32'hFFFFBEEF, 32'h0);
    dm_op(0, 0, 1, 32'h25, 3'b000, 32'h0, 32'hBEEF0000);
    dm_op(0, 1, 0, 32'h28, 3'b111, 32'hCAFEF00D, 32'h0);
    dm_op(0, 0, 1, 32'h28, 3'b010, 32'h0, 32'hCAFEF00D);
  endtask

  task automatic test_out_of_range();
    dm_op(0, 1, 0, 32'h0, 3'b010, 32'h13579BDF, 32'h0);
    dm_op(0, 1, 0, 32'h1000, 3'b010, 32'hFFFFFFFF, 32'h0);
    dm_op(0, 0, 1, 32'h1000, 3'b010, 32'h0, 32'h0);
    dm_op(0, 0, 1, 32'h0, 3'b010, 32'h0, 32'h13579BDF);
    dm_op(0, 0, 1, 32'h8000_0020, 3'b010, 32'h0, 32'h0);
  endtask

  task automatic test_arbitration();
    exp_t e;
    int   t, s;
    rst = 1;
    repeat (2) @(posedge clk);
    #1; rst = 0;
    t = cyc;
    ic_req = 1; ic_addr = 32'h10;
    dm_rd = 1;  dm_addr = 32'h20; dm_f3 = 3'b010;
    e.rd = 1; e.data = 32'hAA117788; e.due = t + 2; q_dm.push_back(e);
    e.rd = 1; e.data = 32'h00500093; e.due = t + 5; q_ic.push_back(e);
    repeat (3) begin @(posedge clk); #1; end
    dm_rd = 0;
    repeat (3) begin @(posedge clk); #1; end
    s = cyc;
    dm_rd = 1;
    for (int k = 0; k < 2; k++) begin
      e.rd = 1; e.data = 32'hAA117788; e.due = s + 2 + 6*k; q_dm.push_back(e);
      e.rd = 1; e.data = 32'h00500093; e.due = s + 5 + 6*k; q_ic.push_back(e);
    end
    repeat (12) begin @(posedge clk); #1; end
    dm_rd = 0; ic_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    dm_op(0, 1, 0, 32'h40, 3'b010, 32'hDEADBEEF, 32'h0);
    dm_wen = 1; dm_addr = 32'h40; dm_f3 = 3'b010; dm_wd = 32'h12345678;
    @(posedge clk); #2;
    rst = 1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (ic_ready !== 1'b0) begin failures++; $display("FAIL abort_ic_ready got=%b want=0", ic_ready); end
    checks++; if (dm_ready !== 1'b0) begin failures++; $display("FAIL abort_dm_ready got=%b want=0", dm_ready); end
    checks++; if (ic_instr !== 32'h0) begin failures++; $display("FAIL abort_ic_instr got=%h want=0", ic_instr); end
    checks++; if (dm_rdata !== 32'h0) begin failures++; $display("FAIL abort_dm_rdata got=%h want=0", dm_rdata); end
    dm_wen = 0;
    repeat (2) @(posedge clk);
    #1; rst = 0;
    @(posedge clk); #1;
    dm_op(0, 0, 1, 32'h40, 3'b010, 32'h0, 32'hDEADBEEF);
  endtask

  task automatic test_latency1();
    exp_t e;
    dm_op(1, 1, 0, 32'h08, 3'b010, 32'h11112222, 32'h0);
    dm_op(1, 1, 0, 32'h0C, 3'b010, 32'h33334444, 32'h0);
    dm1_rd = 1; dm1_f3 = 3'b010;
    for (int k = 0; k < 4; k++) begin
      dm1_addr = (k % 2 == 0) ? 32'h08 : 32'h0C;
      e.rd = 1; e.data = (k % 2 == 0) ? 32'h11112222 : 32'h33334444; e.due = cyc + 1;
      q_dm1.push_back(e);
      repeat (2) begin @(posedge clk); #1; end
    end
    dm1_rd = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_drain();
    repeat (6) @(posedge clk);
    checks++; if (q_ic.size() !== 0) begin failures++; $display("FAIL ic_missing_ready left=%0d want=0", q_ic.size()); end
    checks++; if (q_dm.size() !== 0) begin failures++; $display("FAIL dm_missing_ready left=%0d want=0", q_dm.size()); end
    checks++; if (q_dm1.size() !== 0) begin failures++; $display("FAIL dm1_missing_ready left=%0d want=0", q_dm1.size()); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 0;
    @(posedge clk); #1;
    test_fetch();
    test_byte_half();
    test_out_of_range();
    test_arbitration();
    test_reset_abort();
    test_latency1();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout cyc=%0d limit=20000", cyc);
    $fatal(1, "timeout");
  end

endmodule
